idct_block_sink: RTL and testbench
==================================

Name: idct_block_sink

Overview:
- Receiving end of the idct output stream.
- Captures each 64-sample block the idct presents while its done is high, and reduces every 32-bit fixed-point sample to an 8-bit pixel taken from bits [24:17].
- Buffers blocks in a two-bank ping-pong store and replays them in arrival order to a downstream pixel consumer over a valid/ready handshake.
- Replaces the file-dump sink in hardware-in-loop and FPGA builds of the dct/idct chain.

Parameters:
- DATA_W, 32, width of idct dout.
- PIX_LSB, 17, LSB of the 8-bit pixel field (pixel = in_data[PIX_LSB+7:PIX_LSB]).
- BLK_LEN, 64, samples per block.
- CNT_W, 16, width of the block and drop counters.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_done  in  1  idct done; high while a block is presented.
- in_data  in  DATA_W  idct dout; one sample per clk while in_done=1.
- out_valid  out  1  out_pix valid.
- out_ready  in  1  downstream accepts pixel.
- out_pix  out  8  pixel, raster order within the block.
- out_last  out  1  high with the 64th pixel of a block.
- clr_flags  in  1  synchronous clear of sticky flags and counters.
- blk_cnt  out  CNT_W  blocks fully delivered; wraps.
- drop_cnt  out  CNT_W  blocks discarded; saturates at all-ones.
- ovf_flag  out  1  sticky; a block arrived while both banks were full.
- short_flag  out  1  sticky; in_done fell before BLK_LEN samples.

Behaviour:
- Reset: all outputs 0; both banks marked empty; write FSM in W_IDLE, read FSM in R_IDLE; bank RAM contents undefined. Reset asserted mid-block abandons the block with no flags set.
- Sampling: every clk edge with in_done=1 is one sample. Sample k (0..63) of a window writes bank[wsel][k].
- Write FSM:
  - W_IDLE: on in_done=1 with a free bank, capture sample 0 -> W_FILL. With no free bank: -> W_DROP, ovf_flag<=1, drop_cnt++.
  - W_FILL: capture while in_done=1.
    - On the 64th sample: mark bank full, toggle wsel. If in_done is still 1 next cycle -> W_WAIT_LOW, else -> W_IDLE.
    - If in_done=0 before 64 samples: short_flag<=1, drop_cnt++, bank stays empty -> W_IDLE.
  - W_WAIT_LOW: ignore samples beyond 64; -> W_IDLE when in_done=0.
  - W_DROP: ignore samples; -> W_IDLE when in_done=0.
- Read FSM:
  - R_IDLE: when bank[rsel] is full -> R_SEND; out_valid rises the cycle after the commit, with pixel 0 registered.
  - R_SEND: a pixel transfers on out_valid&out_ready. The next pixel is registered on the same edge, so there are no bubbles at out_ready=1.
    - out_pix/out_last hold stable while out_valid=1 and out_ready=0.
    - After the last transfer: free bank[rsel], toggle rsel, blk_cnt++. If the other bank is already full, continue in R_SEND with no idle cycle; else -> R_IDLE.
- Latency: 64th sample edge -> out_valid high 1 cycle later. Steady throughput is 1 pixel/clk.
- Simultaneous events:
  - Read-free and write-claim in the same cycle: the freed bank is available to W_IDLE in that cycle (same-cycle free is visible).
  - clr_flags together with a flag-setting event: the set wins. Counters clear to 0 and then take the same-cycle increment (result 1).
- Pixel extraction without the optional feature: raw slice in_data[24:17], no rounding.

Optional Feature:
- Macro: IDCT_SINK_SAT_EN.
- Defined: saturating conversion.
  - in_data[31]=1 -> 0x00.
  - Else any of in_data[30:25]=1 -> 0xFF.
  - Else in_data[24:17].
- Undefined: raw slice only, bit-exact with existing idctdata.txt dumps.

Decomposition:
- Package idct_sink_pkg:
  - write-state enum (W_IDLE, W_FILL, W_WAIT_LOW, W_DROP)
  - read-state enum (R_IDLE, R_SEND)
  - BLK_LEN, PIX_W=8 constants
  - pixel-extract function (saturating variant under the macro)
- Sub-module idct_sink_bank: single 64x8 bank with write port, registered read port, and a full bit. Instantiated twice.

Test Plan:
- Single block: in_done high 64 clks, in_data[24:17]=k for k=0..63, out_ready=1 -> out_pix 0..63 on 64 consecutive cycles; first out_valid 1 clk after sample 63; out_last with 63; blk_cnt=1.
- Back-pressure: out_ready toggling 1,0,1,0 -> every value 0..63 delivered exactly once and held while ready=0; no loss.
- Overflow: three back-to-back 64-sample windows (1 idle clk between), out_ready=0 -> blocks 1-2 buffered, third dropped, ovf_flag=1, drop_cnt=1. Then out_ready=1 -> 128 pixels, blk_cnt=2.
- Short block: in_done high 40 clks -> no output, short_flag=1, drop_cnt=1. A following full block is delivered normally.
- Saturation (IDCT_SINK_SAT_EN): samples 0x8000_0000, 0x0200_0000, 0x0150_0000 -> 0x00, 0xFF, 0xA8. Without the macro the same samples give 0x00, 0x00, 0xA8.
- Reset mid-fill: reset_n low at sample 30 -> all outputs 0 asynchronously. After release, a full block is delivered with blk_cnt=1 and no flags set.

Source files
------------

// File: rtl/idct_sink_pkg.sv
// ---------------------------------------------------------------------------
// idct_sink_pkg
// Shared constants, FSM state types and the sample-to-pixel conversion used
// by the idct block sink.
//
// Build option:
//   IDCT_SINK_SAT_EN  defined   -> saturating conversion (negative -> 0x00,
//                                  above the pixel field -> 0xFF)
//                     undefined -> raw bit slice, bit-exact with the old
//                                  idctdata.txt dumps
// ---------------------------------------------------------------------------
package idct_sink_pkg;

  localparam int BLK_LEN = 64;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_WAIT_LOW,
    W_DROP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rstate_e;

  // i_sign   : sample MSB
  // i_hi_any : OR of all bits between the MSB and the pixel field
  // i_field  : the 8-bit pixel field itself
  function automatic logic [PIX_W-1:0] pix_extract(
    input logic             i_sign,
    input logic             i_hi_any,
    input logic [PIX_W-1:0] i_field
  );
`ifdef IDCT_SINK_SAT_EN
    if (i_sign) begin
      return '0;
    end
    if (i_hi_any) begin
      return '1;
    end
    return i_field;
`else
    logic unused_sat;
    unused_sat = i_sign | i_hi_any;
    return i_field;
`endif
  endfunction

endpackage

// File: rtl/idct_sink_bank.sv
// ---------------------------------------------------------------------------
// idct_sink_bank
// One block buffer of the ping-pong store: DEPTH x PIX_W RAM with a write
// port, a registered read port (output holds when i_re=0) and a full bit.
//
// Ports:
//   clk, reset_n         clock / async active-low reset
//   i_we/i_waddr/i_wdata write port
//   i_re/i_raddr/o_rdata registered read port, o_rdata cleared by reset
//   i_set_full           mark bank full (block committed)
//   i_clr_full           mark bank empty (block delivered)
//   o_full               bank holds a complete, undelivered block
// ---------------------------------------------------------------------------
module idct_sink_bank
  import idct_sink_pkg::*;
#(
  parameter int DEPTH = BLK_LEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [PIX_W-1:0] o_rdata,
  input  logic             i_set_full,
  input  logic             i_clr_full,
  output logic             o_full
);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rdata;
  logic             r_full;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register is reset so the sink's pixel output is 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
    end else if (i_clr_full) begin
      r_full <= 1'b0;
    end else if (i_set_full) begin
      r_full <= 1'b1;
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = r_full;

endmodule

// File: rtl/idct_block_sink.sv
// ---------------------------------------------------------------------------
// idct_block_sink
// Receiving end of the idct output stream. Captures each BLK_LEN-sample
// window presented while in_done is high, converts every sample to an 8-bit
// pixel, buffers blocks in two ping-pong banks and replays them in arrival
// order over a valid/ready pixel interface.
//
// Build option: IDCT_SINK_SAT_EN selects saturating pixel conversion
// (see idct_sink_pkg::pix_extract); default is the raw bit slice.
//
// Ports:
//   clk, reset_n    clock / asynchronous active-low reset
//   in_done,in_data idct stream, one sample per clk while in_done=1
//   out_valid/out_ready/out_pix/out_last  pixel stream, out_last on pixel 63
//   clr_flags       synchronous clear of flags and counters (a same-cycle
//                   set/increment still takes effect)
//   blk_cnt         blocks fully delivered (wraps)
//   drop_cnt        blocks discarded (saturates)
//   ovf_flag        sticky: block arrived with both banks full
//   short_flag      sticky: in_done fell before BLK_LEN samples
// ---------------------------------------------------------------------------
module idct_block_sink
  import idct_sink_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PIX_LSB = 17,
  parameter int BLK_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_done,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic              out_last,
  input  logic              clr_flags,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              ovf_flag,
  output logic              short_flag
);

  localparam int            AW       = $clog2(BLK_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(BLK_LEN - 1);

  // Pixel conversion
  logic             w_sign;
  logic             w_hi_any;
  logic [PIX_W-1:0] w_field;
  logic [PIX_W-1:0] w_pix;
  logic             w_unused_lo;

  assign w_sign      = in_data[DATA_W-1];
  assign w_hi_any    = |in_data[DATA_W-2:PIX_LSB+PIX_W];
  assign w_field     = in_data[PIX_LSB+PIX_W-1:PIX_LSB];
  assign w_unused_lo = ^in_data[PIX_LSB-1:0];
  assign w_pix       = pix_extract(w_sign, w_hi_any, w_field);

  // Shared state
  wstate_e         r_wstate, w_wstate_nxt;
  rstate_e         r_rstate, w_rstate_nxt;
  logic            r_wsel;
  logic [AW-1:0]   r_widx;
  logic            r_rsel;
  logic            r_osel;
  logic [AW-1:0]   r_oidx;

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic            w_commit;
  logic            w_set_ovf;
  logic            w_set_short;
  logic            w_drop_inc;
  logic            w_bank_free;

  logic            w_re;
  logic            w_rbank;
  logic [AW-1:0]   w_raddr;
  logic            w_rd_free;
  logic            w_blk_inc;

  logic [1:0]       w_full;
  logic [1:0]       w_bank_we;
  logic [1:0]       w_bank_re;
  logic [1:0]       w_bank_set;
  logic [1:0]       w_bank_clr;
  logic [PIX_W-1:0] w_rdata [2];

  // Ping-pong banks
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_bank_we[b]  = w_we      && (r_wsel  == 1'(b));
    assign w_bank_set[b] = w_commit  && (r_wsel  == 1'(b));
    assign w_bank_re[b]  = w_re      && (w_rbank == 1'(b));
    assign w_bank_clr[b] = w_rd_free && (r_rsel  == 1'(b));

    idct_sink_bank #(
      .DEPTH (BLK_LEN),
      .AW    (AW)
    ) u_bank (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_we       (w_bank_we[b]),
      .i_waddr    (w_waddr),
      .i_wdata    (w_pix),
      .i_re       (w_bank_re[b]),
      .i_raddr    (w_raddr),
      .o_rdata    (w_rdata[b]),
      .i_set_full (w_bank_set[b]),
      .i_clr_full (w_bank_clr[b]),
      .o_full     (w_full[b])
    );
  end

  // Writer always fills bank r_wsel; a bank freed by the reader on this
  // very edge counts as free so back-to-back traffic never drops a block.
  assign w_bank_free = !w_full[r_wsel] || (w_rd_free && (r_rsel == r_wsel));

  // Write FSM
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_we         = 1'b0;
    w_waddr      = r_widx;
    w_commit     = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_short  = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (in_done) begin
          if (w_bank_free) begin
            w_we         = 1'b1;
            w_waddr      = '0;
            w_wstate_nxt = W_FILL;
          end else begin
            w_set_ovf    = 1'b1;
            w_drop_inc   = 1'b1;
            w_wstate_nxt = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (in_done) begin
          w_we = 1'b1;
          // After the last sample, wait for in_done to drop so an overlong
          // window is not mistaken for the start of a new block.
          if (r_widx == LAST_IDX) begin
            w_commit     = 1'b1;
            w_wstate_nxt = W_WAIT_LOW;
          end
        end else begin
          w_set_short  = 1'b1;
          w_drop_inc   = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      W_WAIT_LOW, W_DROP: begin
        if (!in_done) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wstate <= W_IDLE;
      r_wsel   <= 1'b0;
      r_widx   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_we) begin
        r_widx <= w_waddr + 1'b1;
      end
      if (w_commit) begin
        r_wsel <= ~r_wsel;
      end
    end
  end

  // Read FSM: the bank read register is the output register, so a read is
  // issued only when the displayed pixel is consumed (or a block starts).
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_re         = 1'b0;
    w_rbank      = r_rsel;
    w_raddr      = '0;
    w_rd_free    = 1'b0;
    w_blk_inc    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_full[r_rsel]) begin
          w_re         = 1'b1;
          w_rstate_nxt = R_SEND;
        end
      end
      R_SEND: begin
        if (out_ready) begin
          if (r_oidx != LAST_IDX) begin
            w_re    = 1'b1;
            w_raddr = r_oidx + 1'b1;
          end else begin
            w_rd_free = 1'b1;
            w_blk_inc = 1'b1;
            if (w_full[~r_rsel]) begin
              w_re    = 1'b1;
              w_rbank = ~r_rsel;
            end else begin
              w_rstate_nxt = R_IDLE;
            end
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rstate <= R_IDLE;
      r_rsel   <= 1'b0;
      r_osel   <= 1'b0;
      r_oidx   <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_rd_free) begin
        r_rsel <= ~r_rsel;
      end
      if (w_re) begin
        r_osel <= w_rbank;
        r_oidx <= w_raddr;
      end
    end
  end

  // Status flags and counters: clear first, then apply same-cycle events
  logic             r_ovf;
  logic             r_short;
  logic [CNT_W-1:0] r_blk_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_blk_base;
  logic [CNT_W-1:0] w_drop_base;

  assign w_blk_base  = clr_flags ? '0 : r_blk_cnt;
  assign w_drop_base = clr_flags ? '0 : r_drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf      <= 1'b0;
      r_short    <= 1'b0;
      r_blk_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end else if (clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_set_short) begin
        r_short <= 1'b1;
      end else if (clr_flags) begin
        r_short <= 1'b0;
      end
      r_blk_cnt <= w_blk_inc ? w_blk_base + 1'b1 : w_blk_base;
      if (w_drop_inc && (w_drop_base != '1)) begin
        r_drop_cnt <= w_drop_base + 1'b1;
      end else begin
        r_drop_cnt <= w_drop_base;
      end
    end
  end

  // Outputs
  assign out_valid  = (r_rstate == R_SEND);
  assign out_pix    = w_rdata[r_osel];
  assign out_last   = out_valid && (r_oidx == LAST_IDX);
  assign blk_cnt    = r_blk_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign ovf_flag   = r_ovf;
  assign short_flag = r_short;

endmodule

// File: tb/tb_idct_block_sink.sv
// ---------------------------------------------------------------------------
// tb_idct_block_sink
// Directed bench for idct_block_sink. Expected pixels are queued as samples
// are driven and popped when the sink transfers a pixel.
// ---------------------------------------------------------------------------
module tb_idct_block_sink;

  typedef struct packed {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_done;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        out_last;
  logic        clr_flags;
  logic [15:0] blk_cnt;
  logic [15:0] drop_cnt;
  logic        ovf_flag;
  logic        short_flag;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  bit          held_v;
  logic [7:0]  held_pix;
  logic        held_last;
  int          cyc;
  logic [31:0] sp_word [3];
  logic [7:0]  sp_pix  [3];

  always #5 clk = ~clk;

  idct_block_sink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_done    (in_done),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pix    (out_pix),
    .out_last   (out_last),
    .clr_flags  (clr_flags),
    .blk_cnt    (blk_cnt),
    .drop_cnt   (drop_cnt),
    .ovf_flag   (ovf_flag),
    .short_flag (short_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, return 1ns after rising.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (held_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pix",   32'(out_pix),   32'(held_pix));
      chk("hold_last",  32'(out_last),  32'(held_last));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_xfer", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pix",  32'(out_pix),  32'(e.pix));
        chk("last", 32'(out_last), 32'(e.last));
      end
    end
    held_v    = (out_valid === 1'b1) && (out_ready === 1'b0);
    held_pix  = out_pix;
    held_last = out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int n, input int base, input bit push, input bit special);
    exp_t       e;
    logic [7:0] p;
    for (int k = 0; k < n; k++) begin
      p       = 8'(base + k);
      in_data = {7'd0, p, 17'($urandom)};
      if (special && k < 3) begin
        in_data = sp_word[k];
        p       = sp_pix[k];
      end
      in_done = 1'b1;
      if (push) begin
        e.pix  = p;
        e.last = (k == 63);
        exp_q.push_back(e);
      end
      tick();
    end
    in_done = 1'b0;
    in_data = '0;
  endtask

  task automatic drain(input bit toggle, input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc && !(exp_q.size() == 0 && out_valid === 1'b0)) begin
      if (toggle) out_ready = ~out_ready;
      else        out_ready = 1'b1;
      tick();
      n++;
    end
    chk("drain_done", {30'd0, exp_q.size() == 0, out_valid}, 32'd2);
  endtask

  initial begin
    sp_word[0] = 32'h8000_0000;
    sp_word[1] = 32'h0200_0000;
    sp_word[2] = 32'h0150_0000;
`ifdef IDCT_SINK_SAT_EN
    sp_pix[0] = 8'h00;
    sp_pix[1] = 8'hFF;
    sp_pix[2] = 8'hA8;
`else
    sp_pix[0] = 8'h00;
    sp_pix[1] = 8'h00;
    sp_pix[2] = 8'hA8;
`endif
    held_v    = 1'b0;
    reset_n   = 1'b0;
    in_done   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_pix",   32'(out_pix),    32'd0);
    chk("rst_last",  32'(out_last),   32'd0);
    chk("rst_blk",   32'(blk_cnt),    32'd0);
    chk("rst_drop",  32'(drop_cnt),   32'd0);
    chk("rst_ovf",   32'(ovf_flag),   32'd0);
    chk("rst_short", 32'(short_flag), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single block, latency and no-bubble streaming
    out_ready = 1'b1;
    send_block(64, 0, 1'b1, 1'b0);
    chk("lat_early", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("first_pix", 32'(out_pix),   32'd0);
    drain(1'b0, 200, cyc);
    chk("single_cycles", 32'(cyc),     32'd64);
    chk("single_blk",    32'(blk_cnt), 32'd1);

    // Back-pressure with out_ready toggling
    send_block(64, 100, 1'b1, 1'b0);
    drain(1'b1, 400, cyc);
    chk("bp_blk", 32'(blk_cnt), 32'd2);

    // Overflow: two blocks buffered, third dropped
    out_ready = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_blk", 32'(blk_cnt), 32'd0);
    send_block(64, 10, 1'b1, 1'b0);
    tick();
    send_block(64, 80, 1'b1, 1'b0);
    tick();
    send_block(64, 150, 1'b0, 1'b0);
    tick();
    chk("ovf_flag",  32'(ovf_flag),   32'd1);
    chk("ovf_drop",  32'(drop_cnt),   32'd1);
    chk("ovf_short", 32'(short_flag), 32'd0);
    chk("ovf_held",  32'(out_pix),    32'd10);
    drain(1'b0, 300, cyc);
    chk("ovf_cycles", 32'(cyc),     32'd128);
    chk("ovf_blk",    32'(blk_cnt), 32'd2);

    // Short block; in_done falls in the same cycle as clr_flags
    send_block(40, 60, 1'b0, 1'b0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("short_flag", 32'(short_flag), 32'd1);
    chk("short_drop", 32'(drop_cnt),   32'd1);
    chk("short_ovf",  32'(ovf_flag),   32'd0);
    chk("short_blk",  32'(blk_cnt),    32'd0);
    tick();
    tick();
    chk("short_noout", 32'(out_valid), 32'd0);
    send_block(64, 200, 1'b1, 1'b0);
    drain(1'b0, 200, cyc);
    chk("after_short_blk", 32'(blk_cnt), 32'd1);

    // Conversion of out-of-range samples
    send_block(64, 0, 1'b1, 1'b1);
    drain(1'b0, 200, cyc);
    chk("sat_blk", 32'(blk_cnt), 32'd2);

    // Reset in the middle of a fill with a block pending at the output
    out_ready = 1'b0;
    send_block(64, 50, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_pix",   32'(out_pix),   32'd50);
    send_block(30, 90, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("mrst_valid", 32'(out_valid),  32'd0);
    chk("mrst_pix",   32'(out_pix),    32'd0);
    chk("mrst_last",  32'(out_last),   32'd0);
    chk("mrst_blk",   32'(blk_cnt),    32'd0);
    chk("mrst_drop",  32'(drop_cnt),   32'd0);
    chk("mrst_ovf",   32'(ovf_flag),   32'd0);
    chk("mrst_short", 32'(short_flag), 32'd0);
    exp_q.delete();
    held_v = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_block(64, 7, 1'b1, 1'b0);
    drain(1'b0, 200, cyc);
    chk("post_rst_blk",   32'(blk_cnt),    32'd1);
    chk("post_rst_ovf",   32'(ovf_flag),   32'd0);
    chk("post_rst_short", 32'(short_flag), 32'd0);
    chk("post_rst_drop",  32'(drop_cnt),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
